cpu7_csr_wrpipe: RTL and testbench

- Write-side companion of the CSR read-bypass logic.
- Captures CSR write requests (csrwr/csrxchg) at decode and stages them through E, M and W.
- Presents per-stage write enable, address and data to the decode-stage CSR bypass mux.
- Issues exactly one commit write per retired instruction to the CSR register file at W.

---
 rtl/cpu7_csr_wrpipe_pkg.sv | 24 ++
 rtl/cpu7_csr_wrstage.sv | 44 ++++
 rtl/cpu7_csr_wrpipe.sv | 97 +++++++++
 tb/tb_cpu7_csr_wrpipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_csr_wrpipe_pkg.sv
// Shared constants and stage-control helpers for the CSR write pipeline.
// The CPU7_CSR_XCHG_EN macro (see cpu7_csr_wrpipe.sv) does not affect this package.
package cpu7_csr_wrpipe_pkg;

  localparam int unsigned LSOC1K_CSR_BIT = 14;
  localparam int unsigned GRLEN          = 32;
  localparam int unsigned CSR_PAYLOAD_W  = LSOC1K_CSR_BIT + GRLEN + 1;

  typedef enum logic [1:0] {
    STG_ADVANCE,
    STG_HOLD,
    STG_KILL,
    STG_DROP
  } stage_op_e;

  // Kill beats hold beats load; with none asserted the stage empties.
  function automatic stage_op_e stage_op(input logic load, input logic kill, input logic hold);
    if (kill) return STG_KILL;
    if (hold) return STG_HOLD;
    if (load) return STG_ADVANCE;
    return STG_DROP;
  endfunction

endpackage

// File: rtl/cpu7_csr_wrstage.sv
// One CSR write pipeline stage holding a packed {valid, addr, data} payload.
// Address/data only update when a valid request is loaded, so idle stages do not toggle.
module cpu7_csr_wrstage
  import cpu7_csr_wrpipe_pkg::*;
#(
  parameter int unsigned PW = CSR_PAYLOAD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          kill_i,
  input  logic          hold_i,
  input  logic [PW-1:0] pl_i,
  output logic [PW-1:0] pl_o
);

  logic [PW-1:0] pl_q;
  logic [PW-1:0] pl_d;

  always_comb begin
    pl_d = pl_q;
    unique case (stage_op(load_i, kill_i, hold_i))
      STG_ADVANCE: begin
        pl_d[PW-1] = pl_i[PW-1];
        if (pl_i[PW-1]) begin
          pl_d[PW-2:0] = pl_i[PW-2:0];
        end
      end
      STG_HOLD: pl_d = pl_q;
      STG_KILL, STG_DROP: pl_d[PW-1] = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pl_q <= '0;
    end else begin
      pl_q <= pl_d;
    end
  end

  assign pl_o = pl_q;

endmodule

// File: rtl/cpu7_csr_wrpipe.sv
// CSR write pipeline: captures csrwr/csrxchg at D, stages through E/M/W, commits once at W.
// Define CPU7_CSR_XCHG_EN to enable the csrxchg mask merge; otherwise write data passes through.
module cpu7_csr_wrpipe
  import cpu7_csr_wrpipe_pkg::*;
#(
  parameter int unsigned CSR_AW = LSOC1K_CSR_BIT,
  parameter int unsigned DW     = GRLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_wen_d,
  input  logic [CSR_AW-1:0] csr_waddr_d,
  input  logic [DW-1:0]     csr_wdata_d,
  input  logic [DW-1:0]     csr_wmask_d,
  input  logic              csr_xchg_d,
  input  logic [DW-1:0]     csr_rdata_d,
  input  logic              stall,
  input  logic              flush_m,
  output logic              csr_wen_e,
  output logic [CSR_AW-1:0] csr_waddr_e,
  output logic [DW-1:0]     csr_wdata_e,
  output logic              csr_wen_m,
  output logic [CSR_AW-1:0] csr_waddr_m,
  output logic [DW-1:0]     csr_wdata_m,
  output logic              csr_wen_w,
  output logic [CSR_AW-1:0] csr_waddr_w,
  output logic [DW-1:0]     csr_wdata_w,
  output logic              csr_wr_pending
);

  localparam int unsigned PW = CSR_AW + DW + 1;

  logic [DW-1:0] data_req;
  logic [PW-1:0] pl_req;
  logic [PW-1:0] pl_e;
  logic [PW-1:0] pl_m;
  logic [PW-1:0] pl_w;
  logic          advance;

`ifdef CPU7_CSR_XCHG_EN
  assign data_req = csr_xchg_d ? ((csr_wdata_d & csr_wmask_d) | (csr_rdata_d & ~csr_wmask_d))
                               : csr_wdata_d;
`else
  logic unused_xchg;
  assign unused_xchg = ^{csr_wmask_d, csr_xchg_d, csr_rdata_d};
  assign data_req    = csr_wdata_d;
`endif

  assign pl_req  = {csr_wen_d, csr_waddr_d, data_req};
  assign advance = ~stall & ~flush_m;

  cpu7_csr_wrstage #(.PW(PW)) u_stage_e (
    .clk   (clk),
    .reset (reset),
    .load_i(advance),
    .kill_i(flush_m),
    .hold_i(stall),
    .pl_i  (pl_req),
    .pl_o  (pl_e)
  );

  cpu7_csr_wrstage #(.PW(PW)) u_stage_m (
    .clk   (clk),
    .reset (reset),
    .load_i(advance),
    .kill_i(flush_m),
    .hold_i(stall),
    .pl_i  (pl_e),
    .pl_o  (pl_m)
  );

  // W never holds its valid bit: a stalled or flushed cycle must not repeat a commit.
  cpu7_csr_wrstage #(.PW(PW)) u_stage_w (
    .clk   (clk),
    .reset (reset),
    .load_i(advance),
    .kill_i(flush_m),
    .hold_i(1'b0),
    .pl_i  (pl_m),
    .pl_o  (pl_w)
  );

  assign csr_wen_e   = pl_e[PW-1];
  assign csr_waddr_e = pl_e[PW-2 -: CSR_AW];
  assign csr_wdata_e = pl_e[DW-1:0];

  assign csr_wen_m   = pl_m[PW-1];
  assign csr_waddr_m = pl_m[PW-2 -: CSR_AW];
  assign csr_wdata_m = pl_m[DW-1:0];

  assign csr_wen_w   = pl_w[PW-1];
  assign csr_waddr_w = pl_w[PW-2 -: CSR_AW];
  assign csr_wdata_w = pl_w[DW-1:0];

  assign csr_wr_pending = csr_wen_e | csr_wen_m;

endmodule

// File: tb/tb_cpu7_csr_wrpipe.sv
// Bench for cpu7_csr_wrpipe: directed vector table plus randomized run against a queue model.
module tb_cpu7_csr_wrpipe;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          csr_wen_d;
  logic [AW-1:0] csr_waddr_d;
  logic [DW-1:0] csr_wdata_d;
  logic [DW-1:0] csr_wmask_d;
  logic          csr_xchg_d;
  logic [DW-1:0] csr_rdata_d;
  logic          stall;
  logic          flush_m;
  logic          csr_wen_e;
  logic [AW-1:0] csr_waddr_e;
  logic [DW-1:0] csr_wdata_e;
  logic          csr_wen_m;
  logic [AW-1:0] csr_waddr_m;
  logic [DW-1:0] csr_wdata_m;
  logic          csr_wen_w;
  logic [AW-1:0] csr_waddr_w;
  logic [DW-1:0] csr_wdata_w;
  logic          csr_wr_pending;

  always #5 clk = ~clk;

  cpu7_csr_wrpipe #(.CSR_AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_wen_d     (csr_wen_d),
    .csr_waddr_d   (csr_waddr_d),
    .csr_wdata_d   (csr_wdata_d),
    .csr_wmask_d   (csr_wmask_d),
    .csr_xchg_d    (csr_xchg_d),
    .csr_rdata_d   (csr_rdata_d),
    .stall         (stall),
    .flush_m       (flush_m),
    .csr_wen_e     (csr_wen_e),
    .csr_waddr_e   (csr_waddr_e),
    .csr_wdata_e   (csr_wdata_e),
    .csr_wen_m     (csr_wen_m),
    .csr_waddr_m   (csr_waddr_m),
    .csr_wdata_m   (csr_wdata_m),
    .csr_wen_w     (csr_wen_w),
    .csr_waddr_w   (csr_waddr_w),
    .csr_wdata_w   (csr_wdata_w),
    .csr_wr_pending(csr_wr_pending)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] merged(input logic [31:0] wd, input logic [31:0] mk,
                                         input logic [31:0] rd, input logic xc);
`ifdef CPU7_CSR_XCHG_EN
    return xc ? ((wd & mk) | (rd & ~mk)) : wd;
`else
    return wd;
`endif
  endfunction

  typedef struct {
    logic          rst, wen, xchg, stall, flush;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, mask, rdata;
    logic          ee, em, ew;
    logic [DW-1:0] de;
    logic [AW-1:0] aw;
    logic [DW-1:0] dw;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic st, input logic fl, input logic ee, input logic em, input logic ew,
                     input logic [DW-1:0] de, input logic [AW-1:0] aw, input logic [DW-1:0] dw);
    vec_t v;
    v.rst = rst; v.wen = wen; v.addr = a; v.wdata = d; v.mask = '0; v.rdata = '0; v.xchg = 1'b0;
    v.stall = st; v.flush = fl; v.ee = ee; v.em = em; v.ew = ew; v.de = de; v.aw = aw; v.dw = dw;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] mk, input logic [DW-1:0] rd, input logic xc,
                       input logic st, input logic fl);
    reset = rst; csr_wen_d = wen; csr_waddr_d = a; csr_wdata_d = d;
    csr_wmask_d = mk; csr_rdata_d = rd; csr_xchg_d = xc; stall = st; flush_m = fl;
  endtask

  // Reference: in-flight writes as a queue tagged with their stage (1 = E, 2 = M).
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   st;
  } ent_t;

  ent_t          q[$];
  logic          m_wv;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  task automatic model_step();
    ent_t nq[$];
    m_wv = 1'b0;
    if (reset || flush_m) begin
      q.delete();
    end else if (!stall) begin
      foreach (q[i]) begin
        if (q[i].st == 2) begin
          m_wv = 1'b1; m_wa = q[i].a; m_wd = q[i].d;
        end else begin
          ent_t e = q[i];
          e.st = 2;
          nq.push_back(e);
        end
      end
      if (csr_wen_d) begin
        ent_t e;
        e.a = csr_waddr_d;
        e.d = merged(csr_wdata_d, csr_wmask_d, csr_rdata_d, csr_xchg_d);
        e.st = 1;
        nq.push_back(e);
      end
      q = nq;
    end
  endtask

  task automatic model_check(input int unsigned cyc);
    logic ee = 1'b0, em = 1'b0;
    foreach (q[i]) begin
      if (q[i].st == 1) begin
        ee = 1'b1;
        chk($sformatf("rnd%0d addr_e", cyc), 32'(csr_waddr_e), 32'(q[i].a));
        chk($sformatf("rnd%0d data_e", cyc), csr_wdata_e, q[i].d);
      end else begin
        em = 1'b1;
        chk($sformatf("rnd%0d addr_m", cyc), 32'(csr_waddr_m), 32'(q[i].a));
        chk($sformatf("rnd%0d data_m", cyc), csr_wdata_m, q[i].d);
      end
    end
    chk($sformatf("rnd%0d wen_e", cyc), 32'(csr_wen_e), 32'(ee));
    chk($sformatf("rnd%0d wen_m", cyc), 32'(csr_wen_m), 32'(em));
    chk($sformatf("rnd%0d wen_w", cyc), 32'(csr_wen_w), 32'(m_wv));
    chk($sformatf("rnd%0d pending", cyc), 32'(csr_wr_pending), 32'(ee | em));
    if (m_wv) begin
      chk($sformatf("rnd%0d addr_w", cyc), 32'(csr_waddr_w), 32'(m_wa));
      chk($sformatf("rnd%0d data_w", cyc), csr_wdata_w, m_wd);
    end
  endtask

  initial begin
    logic [DW-1:0] xexp;
    xexp = merged(32'hFFFF_0000, 32'h0F0F_0F0F, 32'h1234_5678, 1'b1);

    // Directed rows: inputs held for one edge, expectations sampled just after it.
    row(0, 1, 14'h006, 32'h1234, 0, 0, 1, 0, 0, 32'h1234, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 14'h006, 32'h1234);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 14'h010, 32'hA5, 0, 0, 1, 0, 0, 32'hA5, 0, 0);
    for (int i = 0; i < 3; i++) row(0, 1, 14'h0FF, 32'hDEAD, 1, 0, 1, 0, 0, 32'hA5, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 14'h010, 32'hA5);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 14'h01F, 32'h99, 0, 0, 1, 0, 0, 32'h99, 0, 0);
    row(0, 1, 14'h020, 32'hAAAA, 0, 0, 1, 1, 0, 32'hAAAA, 0, 0);
    row(0, 1, 14'h021, 32'hBBBB, 0, 0, 1, 1, 1, 32'hBBBB, 14'h01F, 32'h99);
    row(0, 1, 14'h022, 32'hCCCC, 0, 1, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 14'h030, 32'h30, 0, 0, 1, 0, 0, 32'h30, 0, 0);
    row(0, 1, 14'h031, 32'h31, 0, 0, 1, 1, 0, 32'h31, 0, 0);
    row(0, 1, 14'h032, 32'h32, 1, 1, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 14'h040, 32'h40, 0, 0, 1, 0, 0, 32'h40, 0, 0);
    row(0, 1, 14'h041, 32'h41, 0, 0, 1, 1, 0, 32'h41, 0, 0);
    row(0, 1, 14'h042, 32'h42, 0, 0, 1, 1, 1, 32'h42, 14'h040, 32'h40);
    row(1, 1, 14'h043, 32'h43, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 14'h007, 32'hFFFF_0000, 0, 0, 1, 0, 0, xexp, 0, 0);
    tbl[tbl.size()-1].mask  = 32'h0F0F_0F0F;
    tbl[tbl.size()-1].rdata = 32'h1234_5678;
    tbl[tbl.size()-1].xchg  = 1'b1;
    row(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 14'h007, xexp);
    row(0, 1, 14'h005, 32'h1, 0, 0, 1, 0, 0, 32'h1, 0, 0);
    row(0, 1, 14'h005, 32'h2, 0, 0, 1, 1, 0, 32'h2, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 14'h005, 32'h1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 14'h005, 32'h2);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst wen_e", 32'(csr_wen_e), 0);
    chk("rst wen_m", 32'(csr_wen_m), 0);
    chk("rst wen_w", 32'(csr_wen_w), 0);
    chk("rst pending", 32'(csr_wr_pending), 0);
    chk("rst addr_e", 32'(csr_waddr_e), 0);
    chk("rst data_e", csr_wdata_e, 0);
    chk("rst addr_m", 32'(csr_waddr_m), 0);
    chk("rst data_m", csr_wdata_m, 0);
    chk("rst addr_w", 32'(csr_waddr_w), 0);
    chk("rst data_w", csr_wdata_w, 0);

    foreach (tbl[i]) begin
      vec_t v = tbl[i];
      drive(v.rst, v.wen, v.addr, v.wdata, v.mask, v.rdata, v.xchg, v.stall, v.flush);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d wen_e", i), 32'(csr_wen_e), 32'(v.ee));
      chk($sformatf("row%0d wen_m", i), 32'(csr_wen_m), 32'(v.em));
      chk($sformatf("row%0d wen_w", i), 32'(csr_wen_w), 32'(v.ew));
      chk($sformatf("row%0d pending", i), 32'(csr_wr_pending), 32'(v.ee | v.em));
      if (v.ee) chk($sformatf("row%0d data_e", i), csr_wdata_e, v.de);
      if (v.ew) begin
        chk($sformatf("row%0d addr_w", i), 32'(csr_waddr_w), 32'(v.aw));
        chk($sformatf("row%0d data_w", i), csr_wdata_w, v.dw);
      end
      if (v.rst) begin
        chk($sformatf("row%0d rst addr_w", i), 32'(csr_waddr_w), 0);
        chk($sformatf("row%0d rst data_w", i), csr_wdata_w, 0);
      end
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_step();
    #1;
    for (int unsigned c = 0; c < 3000; c++) begin
      drive($urandom_range(99) == 0, $urandom_range(2) != 0, AW'($urandom_range(15)), $urandom,
            $urandom, $urandom, $urandom_range(1) == 1, $urandom_range(4) == 0,
            $urandom_range(19) == 0);
      @(posedge clk);
      model_step();
      #1;
      model_check(c);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
